// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - fetch-to-decode instruction queue with opcode predecode
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int size  = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [size-1:0] in_pc,
  input  logic [size-1:0] in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [size-1:0] out_pc,
  output logic [size-1:7] out_instr,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_imm_sel,
  output logic            out_illegal
);

  // DEPTH is 2 or 4, so the pointer covers exactly DEPTH slots.
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  // Immediate-select encodings shared with the immediate generator.
  localparam logic [2:0] Imm_I   = 3'd0;
  localparam logic [2:0] Imm_S   = 3'd1;
  localparam logic [2:0] Imm_B   = 3'd2;
  localparam logic [2:0] Imm_U   = 3'd3;
  localparam logic [2:0] Imm_J   = 3'd4;
  localparam logic [2:0] Imm_JR  = 3'd5;
  localparam logic [2:0] Imm_csr = 3'd6;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Payload storage; predecode results travel with each entry.
  logic [size-1:0] pc_mem    [DEPTH];
  logic [size-1:0] instr_mem [DEPTH];
  logic [2:0]      sel_mem   [DEPTH];
  logic            ill_mem   [DEPTH];

  logic            push;
  logic            pop;
  logic [2:0]      pre_sel;
  logic            pre_ill;
  logic [size-1:0] head_instr;

  // Advance a pointer, wrapping from the last slot back to slot 0.
  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    if (p == AW'(DEPTH - 1)) begin
      return '0;
    end
    return p + AW'(1);
  endfunction

  // Handshake status comes only from registered count, never from the other side.
  always_comb begin
    in_ready  = (count < CW'(DEPTH));
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // Predecode the incoming opcode into an immediate select and an illegal flag.
  always_comb begin
    pre_sel = Imm_I;
    pre_ill = 1'b0;
    case (in_instr[6:0])
      OP_JAL:    pre_sel = Imm_J;
      OP_JALR:   pre_sel = Imm_JR;
      OP_IMM,
      OP_LOAD:   pre_sel = Imm_I;
      OP_LUI,
      OP_AUIPC:  pre_sel = Imm_U;
      OP_BRANCH: pre_sel = Imm_B;
      OP_STORE:  pre_sel = Imm_S;
      OP_SYSTEM: pre_sel = in_instr[14] ? Imm_csr : Imm_I;
      OP_REG:    pre_sel = Imm_I;
      default: begin
        pre_sel = Imm_I;
        pre_ill = 1'b1;
      end
    endcase
  end

  // Control state: flush wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload write; no reset needed since out_valid qualifies every read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
      sel_mem[wr_ptr]   <= pre_sel;
      ill_mem[wr_ptr]   <= pre_ill;
    end
  end

  // Head outputs read straight from storage; illegal is masked when empty.
  always_comb begin
    head_instr  = instr_mem[rd_ptr];
    out_pc      = pc_mem[rd_ptr];
    out_instr   = head_instr[size-1:7];
    out_opcode  = head_instr[6:0];
    out_imm_sel = sel_mem[rd_ptr];
    out_illegal = out_valid && ill_mem[rd_ptr];
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - scoreboard bench for fetch_queue
module tb_fetch_queue;

  localparam int DEPTH = 2;

  localparam logic [2:0] Imm_I   = 3'd0;
  localparam logic [2:0] Imm_S   = 3'd1;
  localparam logic [2:0] Imm_B   = 3'd2;
  localparam logic [2:0] Imm_U   = 3'd3;
  localparam logic [2:0] Imm_J   = 3'd4;
  localparam logic [2:0] Imm_JR  = 3'd5;
  localparam logic [2:0] Imm_csr = 3'd6;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [2:0]  sel;
    logic        ill;
  } entry_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:7] out_instr;
  logic [6:0]  out_opcode;
  logic [2:0]  out_imm_sel;
  logic        out_illegal;

  int checks   = 0;
  int failures = 0;

  entry_t sb[$];
  entry_t cur;

  logic [31:0] wrap_instr [6] = '{32'h000000B7, 32'h00000097, 32'h000000E7,
                                  32'h00000033, 32'h00002073, 32'h00000073};
  logic [2:0]  wrap_sel   [6] = '{Imm_U, Imm_U, Imm_JR, Imm_I, Imm_I, Imm_I};

  logic [31:0] dec_instr [5] = '{32'h00002083, 32'h00112023, 32'h00000063,
                                 32'h305FD073, 32'hFFFFFFFF};
  logic [2:0]  dec_sel   [5] = '{Imm_I, Imm_S, Imm_B, Imm_csr, Imm_I};
  logic        dec_ill   [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  fetch_queue #(.DEPTH(DEPTH), .size(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_opcode  (out_opcode),
    .out_imm_sel (out_imm_sel),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic [2:0] sel, input logic ill);
    in_valid  = v;
    in_pc     = pc;
    in_instr  = instr;
    cur.pc    = pc;
    cur.instr = instr;
    cur.sel   = sel;
    cur.ill   = ill;
  endtask

  // One clock: check handshake and head against the scoreboard, then update it.
  task automatic step();
    logic   exp_rdy;
    logic   exp_vld;
    logic   do_push;
    logic   do_pop;
    entry_t head;
    #1;
    exp_rdy = (sb.size() < DEPTH);
    exp_vld = (sb.size() != 0);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, exp_vld);
    if (exp_vld) begin
      head = sb[0];
      chk("out_pc", out_pc, head.pc);
      chk("out_instr", out_instr, head.instr[31:7]);
      chk("out_opcode", out_opcode, head.instr[6:0]);
      chk("out_imm_sel", out_imm_sel, head.sel);
      chk("out_illegal", out_illegal, head.ill);
    end
    do_push = in_valid && exp_rdy;
    do_pop  = exp_vld && out_ready;
    @(posedge clk);
    if (flush) begin
      sb.delete();
    end else begin
      if (do_pop) begin
        void'(sb.pop_front());
      end
      if (do_push) begin
        sb.push_back(cur);
      end
    end
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, Imm_I, 1'b0);

    // Reset values while rst_n is low.
    #3;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_illegal", out_illegal, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // JAL appears one cycle after push.
    drive(1'b1, 32'h100, 32'h00C000EF, Imm_J, 1'b0);
    step();
    drive(1'b0, 32'h0, 32'h0, Imm_I, 1'b0);
    step();
    out_ready = 1'b1;
    step();

    // Fill to DEPTH with decode stalled; third word refused, head held.
    out_ready = 1'b0;
    drive(1'b1, 32'h110, 32'h00000013, Imm_I, 1'b0);
    step();
    drive(1'b1, 32'h114, 32'h00000093, Imm_I, 1'b0);
    step();
    drive(1'b1, 32'h118, 32'h00000113, Imm_I, 1'b0);
    step();
    step();

    // Continuous traffic from full, across pointer wrap.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'(32'h200 + 4 * i), wrap_instr[i], wrap_sel[i], 1'b0);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, Imm_I, 1'b0);
    step();
    step();

    // Predecode of assorted opcodes, including an unsupported one.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(32'h300 + 4 * i), dec_instr[i], dec_sel[i], dec_ill[i]);
      step();
    end
    drive(1'b0, 32'h0, 32'h0, Imm_I, 1'b0);
    step();
    step();

    // Flush with two entries held and a word on the input.
    out_ready = 1'b0;
    drive(1'b1, 32'h400, 32'h00000037, Imm_U, 1'b0);
    step();
    drive(1'b1, 32'h404, 32'h00000017, Imm_U, 1'b0);
    step();
    drive(1'b1, 32'h408, 32'h0000006F, Imm_J, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, Imm_I, 1'b0);
    step();

    // Asynchronous reset mid-cycle with two entries held and a push pending.
    drive(1'b1, 32'h500, 32'h00000023, Imm_S, 1'b0);
    step();
    drive(1'b1, 32'h504, 32'h00000067, Imm_JR, 1'b0);
    step();
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 1'b0);
    chk("async_in_ready", in_ready, 1'b1);
    chk("async_out_illegal", out_illegal, 1'b0);
    @(posedge clk);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 32'h600, 32'h0000007F, Imm_I, 1'b1);
    step();
    drive(1'b0, 32'h0, 32'h0, Imm_I, 1'b0);
    out_ready = 1'b1;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
